// File: rtl/haz_mem_port_arbiter.sv
// Arbiter and access sequencer for the single memory port shared by instruction
// fetch and data access; reports per-requester stalls as the structural hazard.
module haz_mem_port_arbiter #(
    parameter int LAT_W      = 3,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic             mem_req,
    input  logic [LAT_W-1:0] mem_lat,
    input  logic             flush,
    output logic             if_gnt,
    output logic             mem_gnt,
    output logic             if_done,
    output logic             mem_done,
    output logic             port_sel,
    output logic             port_busy,
    output logic             stall_if,
    output logic             stall_mem,
    output logic             str_haz,
    output logic [3:0]       starve_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_MEM
    } state_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e           state_q;
    logic [LAT_W-1:0] cnt_q;
    logic [3:0]       starve_q;
    logic             port_sel_q;
    logic             if_gnt_q;
    logic             mem_gnt_q;

    logic ifr;
    logic win_if;
    logic cnt_zero;

    // A flushed fetch never competes; a starved fetch beats a contending MEM.
    assign ifr      = if_req && !flush;
    assign win_if   = ifr && (!mem_req || (starve_q == STARVE_LIM));
    assign cnt_zero = (cnt_q == '0);

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order in the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            starve_q   <= '0;
            port_sel_q <= 1'b0;
            if_gnt_q   <= 1'b0;
            mem_gnt_q  <= 1'b0;
        end else begin
            if_gnt_q  <= 1'b0;
            mem_gnt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_if) begin
                        state_q    <= BUSY_IF;
                        cnt_q      <= mem_lat;
                        port_sel_q <= 1'b0;
                        if_gnt_q   <= 1'b1;
                        starve_q   <= '0;
                    end else if (mem_req) begin
                        state_q    <= BUSY_MEM;
                        cnt_q      <= mem_lat;
                        port_sel_q <= 1'b1;
                        mem_gnt_q  <= 1'b1;
                        if (!ifr) begin
                            starve_q <= '0;
                        end else if (starve_q != STARVE_LIM) begin
                            starve_q <= starve_q + 4'd1;
                        end
                    end else begin
                        starve_q <= '0;
                    end
                end
                BUSY_IF: begin
                    // A flush abandons the fetch outright, even on its last cycle.
                    if (flush || cnt_zero) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - LAT_W'(1);
                    end
                end
                BUSY_MEM: begin
                    if (cnt_zero) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - LAT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign if_gnt     = if_gnt_q;
    assign mem_gnt    = mem_gnt_q;
    assign if_done    = (state_q == BUSY_IF) && cnt_zero && !flush;
    assign mem_done   = (state_q == BUSY_MEM) && cnt_zero;
    assign port_sel   = port_sel_q;
    assign port_busy  = (state_q != IDLE);
    assign stall_if   = if_req && (state_q != BUSY_IF);
    assign stall_mem  = mem_req && (state_q != BUSY_MEM);
    assign str_haz    = stall_if || stall_mem;
    assign starve_cnt = starve_q;

endmodule
